// File: rtl/seq_divider.sv
// seq_divider: iterative restoring divider, one quotient bit per clock.
// A start/done handshake wraps N trial-subtraction cycles plus one result cycle.
// Optional build macro: SEQ_DIVIDER_SIGNED_EN enables two's-complement
// operands and results (truncating division). Without it, the unit is purely unsigned.
//
// state  | meaning
// -------+-----------------------------------------------------------
// S_IDLE | waiting for start; operands captured on an accepted start
// S_RUN  | N trial subtractions, cnt_q counts 0..N-1
// S_DONE | results visible, done pulses for this single cycle

module seq_divider #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [N-1:0] dividend,
    input  logic [N-1:0] divisor,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] quotient,
    output logic [N-1:0] remainder,
    output logic         div_by_zero
);

    localparam int CW = $clog2(N);
    localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [N-1:0]  dvd_q, dvd_d;        // dividend magnitude, shifted out MSB first
    logic [N-1:0]  dvs_q, dvs_d;        // divisor magnitude
    logic [N-1:0]  rem_q, rem_d;        // partial remainder (always < divisor, fits N bits)
    logic [N-1:0]  quo_q, quo_d;        // quotient bits shifted in LSB first
    logic [N-1:0]  quotient_q, quotient_d;
    logic [N-1:0]  remainder_q, remainder_d;
    logic          dbz_q, dbz_d;

    logic          last_iter;
    logic          divisor_zero;
    logic [N:0]    r_shift;
    logic [N:0]    trial;
    logic          qbit;
    logic [N-1:0]  rem_next;
    logic [N-1:0]  quo_next;
    logic [N-1:0]  quo_fix;
    logic [N-1:0]  rem_fix;
    logic [N-1:0]  dvd_mag;
    logic [N-1:0]  dvs_mag;

    assign last_iter    = (cnt_q == CNT_LAST);
    assign divisor_zero = (divisor == '0);

    // Trial subtraction as a two's-complement add, restoring on borrow.
    assign r_shift  = {rem_q, dvd_q[N-1]};
    assign trial    = r_shift + ~{1'b0, dvs_q} + (N+1)'(1);
    assign qbit     = ~trial[N];
    assign rem_next = qbit ? trial[N-1:0] : r_shift[N-1:0];
    assign quo_next = {quo_q[N-2:0], qbit};

`ifdef SEQ_DIVIDER_SIGNED_EN
    logic neg_q_q, neg_q_d;
    logic neg_r_q, neg_r_d;

    // The core divides magnitudes; the most-negative value maps to its unsigned
    // magnitude, so most-negative / -1 wraps back to most-negative.
    assign dvd_mag = dividend[N-1] ? (~dividend + N'(1)) : dividend;
    assign dvs_mag = divisor[N-1]  ? (~divisor  + N'(1)) : divisor;
    assign quo_fix = neg_q_q ? (~quo_next + N'(1)) : quo_next;
    assign rem_fix = neg_r_q ? (~rem_next + N'(1)) : rem_next;
`else
    assign dvd_mag = dividend;
    assign dvs_mag = divisor;
    assign quo_fix = quo_next;
    assign rem_fix = rem_next;
`endif

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; start is only looked at in S_IDLE.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = divisor_zero ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                if (last_iter) begin
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Handshake outputs decoded from the state.
    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        unique case (state_q)
            S_IDLE:  busy = 1'b0;
            S_RUN:   busy = 1'b1;
            S_DONE: begin
                busy = 1'b1;
                done = 1'b1;
            end
            default: busy = 1'b0;
        endcase
    end

    // Datapath next values. Result registers load on the edge into S_DONE
    // (sign fixup included) so they are valid during the done cycle and stay
    // frozen throughout S_RUN.
    always_comb begin
        cnt_d       = cnt_q;
        dvd_d       = dvd_q;
        dvs_d       = dvs_q;
        rem_d       = rem_q;
        quo_d       = quo_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        dbz_d       = dbz_q;
`ifdef SEQ_DIVIDER_SIGNED_EN
        neg_q_d     = neg_q_q;
        neg_r_d     = neg_r_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    cnt_d = '0;
                    dvd_d = dvd_mag;
                    dvs_d = dvs_mag;
                    rem_d = '0;
                    quo_d = '0;
`ifdef SEQ_DIVIDER_SIGNED_EN
                    neg_q_d = dividend[N-1] ^ divisor[N-1];
                    neg_r_d = dividend[N-1];
`endif
                    if (divisor_zero) begin
                        quotient_d  = '1;
                        remainder_d = dividend;
                        dbz_d       = 1'b1;
                    end
                end
            end
            S_RUN: begin
                cnt_d = cnt_q + CW'(1);
                dvd_d = {dvd_q[N-2:0], 1'b0};
                rem_d = rem_next;
                quo_d = quo_next;
                if (last_iter) begin
                    quotient_d  = quo_fix;
                    remainder_d = rem_fix;
                    dbz_d       = 1'b0;
                end
            end
            default: begin
                cnt_d = cnt_q;
            end
        endcase
    end

    // Datapath and result registers; reset aborts any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q       <= '0;
            dvd_q       <= '0;
            dvs_q       <= '0;
            rem_q       <= '0;
            quo_q       <= '0;
            quotient_q  <= '0;
            remainder_q <= '0;
            dbz_q       <= 1'b0;
`ifdef SEQ_DIVIDER_SIGNED_EN
            neg_q_q     <= 1'b0;
            neg_r_q     <= 1'b0;
`endif
        end else begin
            cnt_q       <= cnt_d;
            dvd_q       <= dvd_d;
            dvs_q       <= dvs_d;
            rem_q       <= rem_d;
            quo_q       <= quo_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            dbz_q       <= dbz_d;
`ifdef SEQ_DIVIDER_SIGNED_EN
            neg_q_q     <= neg_q_d;
            neg_r_q     <= neg_r_d;
`endif
        end
    end

    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_divider.sv
// Testbench for seq_divider (N=8): directed edge cases plus randomized
// operations, checked against an arithmetic reference model.
// Honors SEQ_DIVIDER_SIGNED_EN so the same bench covers both builds.

module tb_seq_divider;

    localparam int N = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [N-1:0] dividend = '0;
    logic [N-1:0] divisor = '0;
    logic         busy;
    logic         done;
    logic [N-1:0] quotient;
    logic [N-1:0] remainder;
    logic         div_by_zero;

    int checks = 0;
    int errors = 0;

    logic [N-1:0] prev_q = '0;
    logic [N-1:0] prev_r = '0;
    logic         prev_z = 1'b0;

    seq_divider #(.N(N)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference: plain integer division with the divide-by-zero convention.
    task automatic model(input logic [N-1:0] a, input logic [N-1:0] b,
                         output logic [N-1:0] q, output logic [N-1:0] r,
                         output logic z);
        int sa;
        int sb;
        if (b == '0) begin
            q = '1;
            r = a;
            z = 1'b1;
        end else begin
`ifdef SEQ_DIVIDER_SIGNED_EN
            sa = $signed(a);
            sb = $signed(b);
            q  = N'(sa / sb);
            r  = N'(sa % sb);
`else
            sa = int'(a);
            sb = int'(b);
            q  = N'(sa / sb);
            r  = N'(sa % sb);
`endif
            z = 1'b0;
        end
    endtask

    // One operation: start in cycle 0, then check busy/done/hold every cycle
    // up to the done cycle. pulse_cyc>0 raises a stray start in that cycle.
    task automatic run_op(input logic [N-1:0] a, input logic [N-1:0] b, input int pulse_cyc);
        logic [N-1:0] eq;
        logic [N-1:0] er;
        logic         ez;
        int           lat;
        model(a, b, eq, er, ez);
        lat = (b == '0) ? 1 : N + 1;
        @(negedge clk);
        chk("idle_busy", 32'(busy), 32'd0);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start    = 1'b0;
        dividend = N'($urandom);
        divisor  = N'($urandom);
        for (int cyc = 1; cyc <= lat; cyc++) begin
            @(negedge clk);
            start = 1'b0;
            chk("busy", 32'(busy), 32'd1);
            chk("done", 32'(done), 32'(cyc == lat));
            if (cyc < lat) begin
                chk("hold_q", 32'(quotient), 32'(prev_q));
                chk("hold_r", 32'(remainder), 32'(prev_r));
                chk("hold_dbz", 32'(div_by_zero), 32'(prev_z));
            end else begin
                chk("quotient", 32'(quotient), 32'(eq));
                chk("remainder", 32'(remainder), 32'(er));
                chk("dbz", 32'(div_by_zero), 32'(ez));
            end
            if (cyc == pulse_cyc) begin
                start    = 1'b1;
                dividend = N'($urandom);
                divisor  = N'($urandom);
            end
        end
        prev_q = eq;
        prev_r = er;
        prev_z = ez;
    endtask

    initial begin
        logic [N-1:0] ra;
        logic [N-1:0] rb;

        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_q", 32'(quotient), 32'd0);
        chk("rst_r", 32'(remainder), 32'd0);
        chk("rst_dbz", 32'(div_by_zero), 32'd0);
        rst_n = 1'b1;

        run_op(8'd100, 8'd7, 0);
        run_op(8'd255, 8'd1, 0);
        run_op(8'd5, 8'd9, 0);
        run_op(8'd255, 8'd255, 0);
        run_op(8'd37, 8'd0, 0);
        run_op(8'd8, 8'd2, 0);
        run_op(8'd200, 8'd3, 4);
        run_op(8'd91, 8'd13, N + 1);
        run_op(8'd0, 8'd0, 1);
        run_op(8'd17, 8'd4, 0);

        // Abort with reset in cycle 5 of an operation.
        @(negedge clk);
        dividend = 8'd123;
        divisor  = 8'd7;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) @(negedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_q", 32'(quotient), 32'd0);
        chk("abort_r", 32'(remainder), 32'd0);
        chk("abort_dbz", 32'(div_by_zero), 32'd0);
        @(negedge clk);
        rst_n  = 1'b1;
        prev_q = '0;
        prev_r = '0;
        prev_z = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("abort_no_done", 32'(done), 32'd0);
        end
        run_op(8'd50, 8'd5, 0);

`ifdef SEQ_DIVIDER_SIGNED_EN
        run_op(8'hF9, 8'h02, 0);
        run_op(8'h07, 8'hFE, 0);
        run_op(8'h80, 8'hFF, 0);
        run_op(8'h80, 8'h00, 0);
`endif

        for (int i = 0; i < 60; i++) begin
            ra = N'($urandom);
            rb = ($urandom_range(0, 7) == 0) ? '0 : N'($urandom);
            run_op(ra, rb, ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 9)) : 0);
        end

        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
